// File: rtl/video_pkg.sv
// Shared constants and types for the video fetch block.
package video_pkg;

  localparam int unsigned WORDS_PER_GROUP = 4;
  localparam int unsigned PIX_PER_GROUP   = 16;
  localparam int unsigned WORD_W          = 16;
  localparam int unsigned SLOT_W          = 3;   // counts 0..WORDS_PER_GROUP
  localparam int unsigned IDX_W           = 2;   // slot index 0..3
  localparam int unsigned DISC_W          = 4;   // stale strobes still in flight
  localparam int unsigned PCNT_W          = 4;   // pixel counter within a group
  localparam int unsigned GROUP_W         = WORDS_PER_GROUP * WORD_W;

  // Byte-lane order of the four words inside a group.
  localparam int unsigned LANE_PIX0  = 0;
  localparam int unsigned LANE_PIX1  = 1;
  localparam int unsigned LANE_ATTR0 = 2;
  localparam int unsigned LANE_ATTR1 = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2,
    TAIL = 2'd3
  } state_e;

endpackage

// File: rtl/video_fetch_shadow.sv
// Shadow buffer: collects returned words, drops stale strobes after an abort,
// and offers a view with the current strobe already bypassed in.
module video_fetch_shadow
  import video_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  logic               abort_i,
  input  logic               consume_i,
  input  logic               next_acc_i,
  input  logic               strobe_i,
  input  logic [WORD_W-1:0]  data_i,
  input  logic [SLOT_W-1:0]  req_cnt_i,
  output logic               full_c_o,
  output logic               fill_done_c_o,
  output logic [GROUP_W-1:0] view_c_o
);

  logic [WORD_W-1:0] words_q [WORDS_PER_GROUP];
  logic [WORD_W-1:0] words_d [WORDS_PER_GROUP];
  logic [SLOT_W-1:0] rcv_cnt_q, rcv_cnt_d;
  logic [DISC_W-1:0] discard_q, discard_d;
  logic [DISC_W-1:0] pending_c;
  logic              accept_c;

  // Strobe acceptance, slot write and bypassed view.
  always_comb begin
    accept_c      = strobe_i && wr_en_i && !abort_i && (discard_q == '0) &&
                    (rcv_cnt_q < SLOT_W'(WORDS_PER_GROUP));
    fill_done_c_o = accept_c && (rcv_cnt_q == SLOT_W'(WORDS_PER_GROUP - 1));
    full_c_o      = (rcv_cnt_q == SLOT_W'(WORDS_PER_GROUP)) || fill_done_c_o;
    words_d       = words_q;
    if (accept_c) begin
      words_d[rcv_cnt_q[IDX_W-1:0]] = data_i;
    end
    view_c_o = {words_d[LANE_ATTR1], words_d[LANE_ATTR0],
                words_d[LANE_PIX1],  words_d[LANE_PIX0]};
  end

  // Receive counter and stale-strobe bookkeeping.
  always_comb begin
    rcv_cnt_d = rcv_cnt_q;
    discard_d = discard_q;
    pending_c = discard_q + DISC_W'(req_cnt_i) + DISC_W'(next_acc_i) - DISC_W'(rcv_cnt_q);
    if (abort_i || consume_i) begin
      rcv_cnt_d = '0;
    end else if (accept_c) begin
      rcv_cnt_d = rcv_cnt_q + SLOT_W'(1);
    end
    if (abort_i) begin
      // A strobe in the abort clk answers the oldest request, which is stale.
      discard_d = (strobe_i && (pending_c != '0)) ? pending_c - DISC_W'(1) : pending_c;
    end else if (strobe_i && (discard_q != '0)) begin
      discard_d = discard_q - DISC_W'(1);
    end
  end

  // Shadow state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(WORDS_PER_GROUP); i++) begin
        words_q[i] <= '0;
      end
      rcv_cnt_q <= '0;
      discard_q <= '0;
    end else begin
      words_q   <= words_d;
      rcv_cnt_q <= rcv_cnt_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: rtl/video_fetch.sv
// Video fetch: requests four words per 16-pixel group from the arbiter and
// hands each completed group to the renderer on the group boundary.
module video_fetch
  import video_pkg::*;
#(
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned GROUPS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cend,
  input  logic               fetch_start,
  input  logic               disp_start,
  input  logic [ADDR_W-1:0]  line_addr,
  output logic [ADDR_W-1:0]  video_addr,
  output logic               video_go,
  input  logic               video_next,
  input  logic               video_strobe,
  input  logic [WORD_W-1:0]  video_data,
  output logic [GROUP_W-1:0] pic_bits,
  output logic               fetch_sync,
  output logic               underrun,
  output logic               line_done
);

  localparam int unsigned GRP_W = $clog2(GROUPS + 1);
  localparam int unsigned BND_W = GRP_W + 1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [SLOT_W-1:0]  req_cnt_q, req_cnt_d;
  logic [GRP_W-1:0]   grp_q, grp_d;
  logic [BND_W-1:0]   bnd_cnt_q, bnd_cnt_d;
  logic               disp_run_q, disp_run_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic [GROUP_W-1:0] pic_q, pic_d;
  logic               underrun_q, underrun_d;
  logic               line_done_q, line_done_d;

  logic               go_c, next_acc_c, bnd_c, consume_c, wr_en_c;
  logic               sh_full_c, sh_fill_done_c;
  logic [GROUP_W-1:0] sh_view_c;

  // Request level, boundary detect and group hand-off condition.
  assign go_c       = (state_q == FILL) && (req_cnt_q < SLOT_W'(WORDS_PER_GROUP));
  assign next_acc_c = video_next && go_c;
  assign bnd_c      = cend && (disp_start ||
                      (disp_run_q && (pcnt_q == PCNT_W'(PIX_PER_GROUP - 1))));
  assign wr_en_c    = (state_q == FILL);
  assign consume_c  = bnd_c && sh_full_c && !fetch_start &&
                      ((state_q == FILL) || (state_q == FULL));

  video_fetch_shadow u_shadow (
    .clk           (clk),
    .rst           (rst),
    .wr_en_i       (wr_en_c),
    .abort_i       (fetch_start),
    .consume_i     (consume_c),
    .next_acc_i    (next_acc_c),
    .strobe_i      (video_strobe),
    .data_i        (video_data),
    .req_cnt_i     (req_cnt_q),
    .full_c_o      (sh_full_c),
    .fill_done_c_o (sh_fill_done_c),
    .view_c_o      (sh_view_c)
  );

  // Next-state logic for the fetch FSM and its counters.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    req_cnt_d   = req_cnt_q;
    grp_d       = grp_q;
    bnd_cnt_d   = bnd_cnt_q;
    disp_run_d  = disp_run_q;
    pcnt_d      = pcnt_q;
    pic_d       = pic_q;
    underrun_d  = underrun_q;
    line_done_d = 1'b0;

    if (next_acc_c) begin
      addr_d    = addr_q + ADDR_W'(1);
      req_cnt_d = req_cnt_q + SLOT_W'(1);
    end
    if (bnd_c) begin
      pcnt_d = '0;
    end else if (cend && disp_run_q) begin
      pcnt_d = pcnt_q + PCNT_W'(1);
    end
    if (cend && disp_start) begin
      disp_run_d = 1'b1;
    end
    if (sh_fill_done_c) begin
      grp_d = grp_q + GRP_W'(1);
    end

    unique case (state_q)
      FILL, FULL: begin
        if (consume_c) begin
          pic_d     = sh_view_c;
          req_cnt_d = '0;
          bnd_cnt_d = bnd_cnt_q + BND_W'(1);
          state_d   = (grp_d < GRP_W'(GROUPS)) ? FILL : TAIL;
        end else if (bnd_c) begin
          // Group not ready: show blank, keep collecting for the next boundary.
          pic_d      = '0;
          underrun_d = 1'b1;
          bnd_cnt_d  = bnd_cnt_q + BND_W'(1);
        end else if (sh_fill_done_c) begin
          state_d = FULL;
        end
      end
      TAIL: begin
        if (bnd_c) begin
          pic_d       = '0;
          disp_run_d  = 1'b0;
          line_done_d = 1'b1;
          bnd_cnt_d   = bnd_cnt_q + BND_W'(1);
          state_d     = IDLE;
        end
      end
      default: begin
      end
    endcase

    // A new line overrides everything else in the same clk.
    if (fetch_start) begin
      state_d     = FILL;
      addr_d      = line_addr;
      req_cnt_d   = '0;
      grp_d       = '0;
      bnd_cnt_d   = '0;
      disp_run_d  = 1'b0;
      pic_d       = pic_q;
      underrun_d  = 1'b0;
      line_done_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      req_cnt_q   <= '0;
      grp_q       <= '0;
      bnd_cnt_q   <= '0;
      disp_run_q  <= 1'b0;
      pcnt_q      <= '0;
      pic_q       <= '0;
      underrun_q  <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      req_cnt_q   <= req_cnt_d;
      grp_q       <= grp_d;
      bnd_cnt_q   <= bnd_cnt_d;
      disp_run_q  <= disp_run_d;
      pcnt_q      <= pcnt_d;
      pic_q       <= pic_d;
      underrun_q  <= underrun_d;
      line_done_q <= line_done_d;
    end
  end

  assign video_addr = addr_q;
  assign video_go   = go_c;
  assign pic_bits   = pic_q;
  assign fetch_sync = bnd_c;
  assign underrun   = underrun_q;
  assign line_done  = line_done_q;

endmodule

// File: tb/tb_video_fetch.sv
// Scoreboard bench for video_fetch: an arbiter/display environment drives the
// DUT, expected boundary loads and request addresses are queued by stimulus.
module tb_video_fetch;

  localparam int unsigned ADDR_W = 21;
  localparam int unsigned GROUPS = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cend = 1'b0;
  logic              fetch_start = 1'b0;
  logic              disp_start = 1'b0;
  logic [ADDR_W-1:0] line_addr = '0;
  logic [ADDR_W-1:0] video_addr;
  logic              video_go;
  logic              video_next = 1'b0;
  logic              video_strobe = 1'b0;
  logic [15:0]       video_data = '0;
  logic [63:0]       pic_bits;
  logic              fetch_sync;
  logic              underrun;
  logic              line_done;

  video_fetch #(.ADDR_W(ADDR_W), .GROUPS(GROUPS)) dut (
    .clk          (clk),
    .rst          (rst),
    .cend         (cend),
    .fetch_start  (fetch_start),
    .disp_start   (disp_start),
    .line_addr    (line_addr),
    .video_addr   (video_addr),
    .video_go     (video_go),
    .video_next   (video_next),
    .video_strobe (video_strobe),
    .video_data   (video_data),
    .pic_bits     (pic_bits),
    .fetch_sync   (fetch_sync),
    .underrun     (underrun),
    .line_done    (line_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pic;
    logic        und;
    logic        done;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              got_e;
  logic [ADDR_W-1:0] addr_q[$];
  logic [15:0]       data_q[$];
  int                due_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int grants = 0;
  int strobes = 0;
  int grant_budget = -1;
  int strobe_budget = -1;
  int rst_hold = 3;
  bit sync_mode = 1'b0;
  bit disp_req = 1'b0;
  bit fs_req = 1'b0;
  logic [ADDR_W-1:0] fs_addr = '0;
  int base_g;
  int base_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_group(input logic [ADDR_W-1:0] base, input logic [15:0] w0,
                            input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3);
    for (int i = 0; i < 4; i++) addr_q.push_back(base + ADDR_W'(i));
    data_q.push_back(w0);
    data_q.push_back(w1);
    data_q.push_back(w2);
    data_q.push_back(w3);
  endtask

  task automatic push_exp(input logic [63:0] p, input logic u, input logic d);
    exp_t e;
    e.pic  = p;
    e.und  = u;
    e.done = d;
    exp_q.push_back(e);
  endtask

  task automatic start_line(input logic [ADDR_W-1:0] a);
    fs_addr = a;
    fs_req  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(input int target, input string name);
    int t = 0;
    while (grants < target && t < 400) begin @(posedge clk); t++; end
    #1;
    if (grants < target) begin
      checks++; errors++;
      $display("FAIL %s: timeout, grants %0d expected %0d", name, grants, target);
    end
  endtask

  task automatic wait_strobes(input int target, input string name);
    int t = 0;
    while (strobes < target && t < 400) begin @(posedge clk); t++; end
    #1;
    if (strobes < target) begin
      checks++; errors++;
      $display("FAIL %s: timeout, strobes %0d expected %0d", name, strobes, target);
    end
  endtask

  task automatic wait_empty(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 800) begin @(posedge clk); t++; end
    #1;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s: timeout, %0d boundaries still expected", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Environment: reset, fetch_start, pixel strobe, arbiter grants and read returns.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_hold > 0) begin rst = 1'b1; rst_hold--; end
      else rst = 1'b0;
      fetch_start = fs_req;
      if (fs_req) begin line_addr = fs_addr; fs_req = 1'b0; end
      cend = ((cyc % 4) == 0);
      disp_start = cend && disp_req;
      if (disp_start) disp_req = 1'b0;
      video_next = 1'b0;
      if (video_go === 1'b1 && grant_budget != 0) begin
        video_next = 1'b1;
        grants++;
        if (grant_budget > 0) grant_budget--;
        due_q.push_back(cyc + 3);
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL grant_addr: unexpected request at %h", video_addr);
        end else begin
          chk("grant_addr", 64'(video_addr), 64'(addr_q.pop_front()));
        end
      end
      video_strobe = 1'b0;
      if (due_q.size() > 0 && strobe_budget != 0 && (!sync_mode || disp_start)) begin
        if (due_q[0] <= cyc) begin
          video_strobe = 1'b1;
          video_data   = (data_q.size() > 0) ? data_q.pop_front() : 16'hFFFF;
          void'(due_q.pop_front());
          strobes++;
          if (strobe_budget > 0) strobe_budget--;
          sync_mode = 1'b0;
        end
      end
    end
  end

  // Monitor: every fetch_sync must match the next queued load.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (fetch_sync === 1'b1) begin
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL boundary: unexpected fetch_sync, pic_bits %h", pic_bits);
        end else begin
          got_e = exp_q.pop_front();
          chk("pic_bits", pic_bits, got_e.pic);
          chk("underrun", 64'(underrun), 64'(got_e.und));
          chk("line_done", 64'(line_done), 64'(got_e.done));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (6) @(posedge clk);
    #1;
    chk("rst_go", 64'(video_go), 64'd0);
    chk("rst_addr", 64'(video_addr), 64'd0);
    chk("rst_pic", pic_bits, 64'd0);
    chk("rst_sync", 64'(fetch_sync), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_line_done", 64'(line_done), 64'd0);

    // Normal line of two groups followed by the blank tail load.
    base_s = strobes;
    push_group(21'h01800, 16'h9988, 16'hBBAA, 16'h2211, 16'h4433);
    push_group(21'h01804, 16'h0102, 16'h0304, 16'h0506, 16'h0708);
    start_line(21'h01800);
    wait_strobes(base_s + 4, "t1_prefetch");
    push_exp(64'h4433_2211_BBAA_9988, 1'b0, 1'b0);
    push_exp(64'h0708_0506_0304_0102, 1'b0, 1'b0);
    push_exp(64'h0, 1'b0, 1'b1);
    disp_req = 1'b1;
    wait_empty("t1_line");

    // Read data stalled past the first boundary.
    base_g = grants;
    strobe_budget = 0;
    push_group(21'h00200, 16'h1000, 16'h2000, 16'h3000, 16'h4000);
    push_group(21'h00204, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
    start_line(21'h00200);
    wait_grants(base_g + 4, "t2_grants");
    repeat (6) @(posedge clk);
    #1;
    chk("t2_go_bound", 64'(video_go), 64'd0);
    push_exp(64'h0, 1'b1, 1'b0);
    disp_req = 1'b1;
    wait_empty("t2_underrun");
    strobe_budget = -1;
    push_exp(64'h4000_3000_2000_1000, 1'b1, 1'b0);
    push_exp(64'h8888_7777_6666_5555, 1'b1, 1'b0);
    push_exp(64'h0, 1'b1, 1'b1);
    wait_empty("t2_line");

    // Fourth word lands in the boundary clk and must bypass into slot 3.
    base_s = strobes;
    strobe_budget = 3;
    push_group(21'h00300, 16'hAAA1, 16'hAAA2, 16'hAAA3, 16'hAAA4);
    push_group(21'h00304, 16'hBBB1, 16'hBBB2, 16'hBBB3, 16'hBBB4);
    start_line(21'h00300);
    wait_strobes(base_s + 3, "t3_three");
    push_exp(64'hAAA4_AAA3_AAA2_AAA1, 1'b0, 1'b0);
    push_exp(64'hBBB4_BBB3_BBB2_BBB1, 1'b0, 1'b0);
    push_exp(64'h0, 1'b0, 1'b1);
    sync_mode = 1'b1;
    strobe_budget = -1;
    disp_req = 1'b1;
    wait_empty("t3_line");

    // Abort with two reads still in flight; they must be discarded.
    base_g = grants;
    base_s = strobes;
    grant_budget = 3;
    strobe_budget = 1;
    addr_q.push_back(21'h00400);
    addr_q.push_back(21'h00401);
    addr_q.push_back(21'h00402);
    data_q.push_back(16'hDEAD);
    data_q.push_back(16'hD001);
    data_q.push_back(16'hD002);
    start_line(21'h00400);
    wait_grants(base_g + 3, "t4_grants");
    wait_strobes(base_s + 1, "t4_first");
    push_group(21'h00480, 16'hE001, 16'hE002, 16'hE003, 16'hE004);
    push_group(21'h00484, 16'hE005, 16'hE006, 16'hE007, 16'hE008);
    start_line(21'h00480);
    grant_budget = -1;
    strobe_budget = -1;
    wait_strobes(base_s + 7, "t4_refill");
    push_exp(64'hE004_E003_E002_E001, 1'b0, 1'b0);
    push_exp(64'hE008_E007_E006_E005, 1'b0, 1'b0);
    push_exp(64'h0, 1'b0, 1'b1);
    disp_req = 1'b1;
    wait_empty("t4_line");

    // Address wrap at the top of the word space.
    base_s = strobes;
    addr_q.push_back(21'h1FFFFE);
    addr_q.push_back(21'h1FFFFF);
    addr_q.push_back(21'h000000);
    addr_q.push_back(21'h000001);
    data_q.push_back(16'h5A01);
    data_q.push_back(16'h5A02);
    data_q.push_back(16'h5A03);
    data_q.push_back(16'h5A04);
    start_line(21'h1FFFFE);
    wait_strobes(base_s + 4, "t5_wrap");
    chk("t5_addr_after", 64'(video_addr), 64'h2);

    // Reset in the middle of a fill with the request raised.
    grant_budget = 0;
    start_line(21'h00100);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_go_pre", 64'(video_go), 64'd1);
    chk("t6_addr_pre", 64'(video_addr), 64'h100);
    push_exp(64'h0, 1'b1, 1'b0);
    disp_req = 1'b1;
    wait_empty("t6_underrun");
    rst_hold = 1;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("t6_rst_go", 64'(video_go), 64'd0);
    chk("t6_rst_addr", 64'(video_addr), 64'd0);
    chk("t6_rst_pic", pic_bits, 64'd0);
    chk("t6_rst_sync", 64'(fetch_sync), 64'd0);
    chk("t6_rst_underrun", 64'(underrun), 64'd0);
    chk("t6_rst_line_done", 64'(line_done), 64'd0);
    grant_budget = -1;
    repeat (80) @(posedge clk);
    #1;
    chk("t6_idle_go", 64'(video_go), 64'd0);
    chk("t6_idle_addr", 64'(video_addr), 64'd0);
    chk("t6_no_grants", 64'(addr_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
